// File: rtl/addr_req_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module : addr_req_demux_pkg
// Brief  : Shared types, default address map and FSM encoding for the demux.
// Rev    : 1.0
// ============================================================================
package addr_req_demux_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned SLV_NUM    = 4;
    localparam int unsigned ADDR_NUM   = 4;
    // One spare index bit so out-of-range rule indices remain representable.
    localparam int unsigned IDX_WIDTH  = $clog2(SLV_NUM) + 1;

    typedef logic [ADDR_WIDTH-1:0]   addr_t;
    typedef logic [DATA_WIDTH-1:0]   data_t;
    typedef logic [DATA_WIDTH/8-1:0] strb_t;
    typedef logic [IDX_WIDTH-1:0]    idx_t;

    // end_addr is exclusive in range mode and acts as the mask in mask mode.
    typedef struct packed {
        addr_t start_addr;
        addr_t end_addr;
        idx_t  index;
    } rule_t;

    localparam rule_t [ADDR_NUM-1:0] DEFAULT_ADDR_MAP = {
        rule_t'{start_addr: 32'h0000_8000, end_addr: 32'h0000_9000, index: idx_t'(3)},
        rule_t'{start_addr: 32'h0000_2000, end_addr: 32'h0000_3000, index: idx_t'(2)},
        rule_t'{start_addr: 32'h0000_1000, end_addr: 32'h0000_2000, index: idx_t'(1)},
        rule_t'{start_addr: 32'h0000_0000, end_addr: 32'h0000_1000, index: idx_t'(0)}
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        ERR_RSP = 2'd2
    } fsm_e;

endpackage : addr_req_demux_pkg
`default_nettype wire

// File: rtl/address_decode.sv
`default_nettype none
// ============================================================================
// Module : address_decode
// Brief  : Combinational rule-table address decoder (range or mask matching).
// Rev    : 1.0
// ============================================================================
module address_decode #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned AddrNum   = 4,
    parameter bit          Napot     = 1'b0,
    parameter type         rule_t    = addr_req_demux_pkg::rule_t,
    parameter type         index_t   = addr_req_demux_pkg::idx_t
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  rule_t [AddrNum-1:0]  addr_map_i,
    output index_t               slv_sel_o,
    output logic                 slv_sel_error_o
);

    logic [AddrNum-1:0] w_match;

    for (genvar i = 0; i < AddrNum; i++) begin : g_rule
        if (Napot) begin : g_mask
            assign w_match[i] = ((addr_i & addr_map_i[i].end_addr) ==
                                 (addr_map_i[i].start_addr & addr_map_i[i].end_addr));
        end else begin : g_range
            assign w_match[i] = (addr_i >= addr_map_i[i].start_addr) &&
                                (addr_i <  addr_map_i[i].end_addr);
        end
    end

    // Scan from the top so the lowest-numbered matching rule wins.
    always_comb begin
        slv_sel_o       = '0;
        slv_sel_error_o = 1'b1;
        for (int i = AddrNum - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                slv_sel_o       = addr_map_i[i].index;
                slv_sel_error_o = 1'b0;
            end
        end
    end

endmodule : address_decode
`default_nettype wire

// File: rtl/addr_req_demux.sv
`default_nettype none
// ============================================================================
// Module : addr_req_demux
// Brief  : Decodes master requests onto one of SlvNum slaves, keeps a single
//          outstanding target so responses return in order; errors terminate.
// Rev    : 1.0
// ============================================================================
module addr_req_demux
    import addr_req_demux_pkg::*;
#(
    parameter int unsigned         AddrWidth = 32,
    parameter int unsigned         DataWidth = 32,
    parameter int unsigned         SlvNum    = 4,
    parameter int unsigned         AddrNum   = 4,
    parameter bit                  Napot     = 1'b0,
    parameter int unsigned         MaxTrans  = 4,
    parameter rule_t [AddrNum-1:0] AddrMap   = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             mst_req_valid,
    output logic                             mst_req_ready,
    input  logic [AddrWidth-1:0]             mst_req_addr,
    input  logic                             mst_req_we,
    input  logic [DataWidth-1:0]             mst_req_wdata,
    input  logic [DataWidth/8-1:0]           mst_req_be,
    output logic                             mst_rsp_valid,
    input  logic                             mst_rsp_ready,
    output logic [DataWidth-1:0]             mst_rsp_rdata,
    output logic                             mst_rsp_err,
    output logic [SlvNum-1:0]                slv_req_valid,
    input  logic [SlvNum-1:0]                slv_req_ready,
    output logic [AddrWidth-1:0]             slv_req_addr,
    output logic                             slv_req_we,
    output logic [DataWidth-1:0]             slv_req_wdata,
    output logic [DataWidth/8-1:0]           slv_req_be,
    input  logic [SlvNum-1:0]                slv_rsp_valid,
    output logic [SlvNum-1:0]                slv_rsp_ready,
    input  logic [SlvNum-1:0][DataWidth-1:0] slv_rsp_rdata,
    input  logic [SlvNum-1:0]                slv_rsp_err
);

    localparam int unsigned CNT_W = $clog2(MaxTrans + 1);
    localparam int unsigned TGT_W = (SlvNum > 1) ? $clog2(SlvNum) : 1;

    idx_t             w_slv_sel;
    logic             w_sel_error;
    logic             w_dec_err;
    logic [TGT_W-1:0] w_sel_tgt;
    logic             w_can_issue;
    logic             w_fwd;
    logic             w_req_hs;
    logic             w_err_hs;
    logic             w_rsp_hs;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TGT_W-1:0] tgt_q, tgt_d;
    fsm_e             fsm_q, fsm_d;

    address_decode #(
        .AddrWidth (AddrWidth),
        .AddrNum   (AddrNum),
        .Napot     (Napot),
        .rule_t    (rule_t),
        .index_t   (idx_t)
    ) u_address_decode (
        .addr_i          (mst_req_addr),
        .addr_map_i      (AddrMap),
        .slv_sel_o       (w_slv_sel),
        .slv_sel_error_o (w_sel_error)
    );

    assign w_dec_err = w_sel_error || (w_slv_sel >= idx_t'(SlvNum));
    assign w_sel_tgt = w_slv_sel[TGT_W-1:0];

    // A new target is only accepted once everything to the old one has drained.
    assign w_can_issue = (fsm_q != ERR_RSP) && (cnt_q < CNT_W'(MaxTrans)) &&
                         ((cnt_q == '0) || ((fsm_q == BUSY) && (tgt_q == w_sel_tgt)));
    assign w_fwd       = !w_dec_err && w_can_issue;

    assign slv_req_addr  = mst_req_addr;
    assign slv_req_we    = mst_req_we;
    assign slv_req_wdata = mst_req_wdata;
    assign slv_req_be    = mst_req_be;

    always_comb begin
        slv_req_valid = '0;
        mst_req_ready = 1'b0;
        if (w_fwd) begin
            slv_req_valid[w_sel_tgt] = mst_req_valid;
            mst_req_ready            = slv_req_ready[w_sel_tgt];
        end else if (w_dec_err && (fsm_q == IDLE)) begin
            mst_req_ready = 1'b1;
        end
    end

    always_comb begin
        mst_rsp_valid = 1'b0;
        mst_rsp_rdata = '0;
        mst_rsp_err   = 1'b0;
        slv_rsp_ready = '0;
        case (fsm_q)
            BUSY: begin
                mst_rsp_valid        = slv_rsp_valid[tgt_q];
                mst_rsp_rdata        = slv_rsp_rdata[tgt_q];
                mst_rsp_err          = slv_rsp_err[tgt_q];
                slv_rsp_ready[tgt_q] = mst_rsp_ready;
            end
            ERR_RSP: begin
                mst_rsp_valid = 1'b1;
                mst_rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_req_hs = mst_req_valid && mst_req_ready && w_fwd;
    assign w_err_hs = mst_req_valid && mst_req_ready && w_dec_err;
    assign w_rsp_hs = (fsm_q == BUSY) && slv_rsp_valid[tgt_q] && mst_rsp_ready;

    always_comb begin
        cnt_d = cnt_q;
        tgt_d = tgt_q;
        fsm_d = fsm_q;
        case ({w_req_hs, w_rsp_hs})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: ;
        endcase
        if (w_req_hs && (cnt_q == '0)) begin
            tgt_d = w_sel_tgt;
            fsm_d = BUSY;
        end
        if (w_rsp_hs && !w_req_hs && (cnt_q == CNT_W'(1))) begin
            fsm_d = IDLE;
        end
        if (w_err_hs) begin
            fsm_d = ERR_RSP;
        end
        if ((fsm_q == ERR_RSP) && mst_rsp_ready) begin
            fsm_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tgt_q <= '0;
            fsm_q <= IDLE;
        end else begin
            cnt_q <= cnt_d;
            tgt_q <= tgt_d;
            fsm_q <= fsm_d;
        end
    end

`ifndef SYNTHESIS
    a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= CNT_W'(MaxTrans));
    a_cnt_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_rsp_hs && (cnt_q == '0)));
`endif

endmodule : addr_req_demux
`default_nettype wire

// File: tb/tb_addr_req_demux.sv
`default_nettype none
// ============================================================================
// Module : tb_addr_req_demux
// Brief  : Directed and random stimulus for addr_req_demux against a
//          transaction-queue reference model.
// Rev    : 1.0
// ============================================================================
module tb_addr_req_demux;
    import addr_req_demux_pkg::*;

    localparam int MAXT = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  mst_req_valid;
    logic                  mst_req_ready;
    logic [31:0]           mst_req_addr;
    logic                  mst_req_we;
    logic [31:0]           mst_req_wdata;
    logic [3:0]            mst_req_be;
    logic                  mst_rsp_valid;
    logic                  mst_rsp_ready;
    logic [31:0]           mst_rsp_rdata;
    logic                  mst_rsp_err;
    logic [3:0]            slv_req_valid;
    logic [3:0]            slv_req_ready;
    logic [31:0]           slv_req_addr;
    logic                  slv_req_we;
    logic [31:0]           slv_req_wdata;
    logic [3:0]            slv_req_be;
    logic [3:0]            slv_rsp_valid;
    logic [3:0]            slv_rsp_ready;
    logic [3:0][31:0]      slv_rsp_rdata;
    logic [3:0]            slv_rsp_err;

    int n_chk  = 0;
    int n_fail = 0;
    int q[$];          // slave ids of accepted, not yet answered requests
    bit err_pend = 0;  // an internally terminated request awaits its response

    always #5 clk = ~clk;

    addr_req_demux #(
        .AddrWidth (32),
        .DataWidth (32),
        .SlvNum    (4),
        .AddrNum   (4),
        .Napot     (1'b0),
        .MaxTrans  (MAXT),
        .AddrMap   (DEFAULT_ADDR_MAP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mst_req_valid (mst_req_valid),
        .mst_req_ready (mst_req_ready),
        .mst_req_addr  (mst_req_addr),
        .mst_req_we    (mst_req_we),
        .mst_req_wdata (mst_req_wdata),
        .mst_req_be    (mst_req_be),
        .mst_rsp_valid (mst_rsp_valid),
        .mst_rsp_ready (mst_rsp_ready),
        .mst_rsp_rdata (mst_rsp_rdata),
        .mst_rsp_err   (mst_rsp_err),
        .slv_req_valid (slv_req_valid),
        .slv_req_ready (slv_req_ready),
        .slv_req_addr  (slv_req_addr),
        .slv_req_we    (slv_req_we),
        .slv_req_wdata (slv_req_wdata),
        .slv_req_be    (slv_req_be),
        .slv_rsp_valid (slv_rsp_valid),
        .slv_rsp_ready (slv_rsp_ready),
        .slv_rsp_rdata (slv_rsp_rdata),
        .slv_rsp_err   (slv_rsp_err)
    );

    // Test map: slave0 0x0xxx, slave1 0x1xxx, slave2 0x2xxx, slave3 0x8xxx.
    function automatic int ref_decode(input logic [31:0] a);
        case (a[31:12])
            20'h00000: return 0;
            20'h00001: return 1;
            20'h00002: return 2;
            20'h00008: return 3;
            default:   return -1;
        endcase
    endfunction

    function automatic logic [31:0] slave_base(input int i);
        return (i == 3) ? 32'h8000 : 32'(i) * 32'h1000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mst_req_valid = 1'b0;
        mst_req_addr  = 32'h0;
        mst_req_we    = 1'b0;
        mst_req_wdata = 32'h0;
        mst_req_be    = 4'h0;
        mst_rsp_ready = 1'b0;
        slv_req_ready = 4'h0;
        slv_rsp_valid = 4'h0;
        slv_rsp_rdata = '0;
        slv_rsp_err   = 4'h0;
    endtask

    // Compare all outputs with the model for the current inputs, advance the
    // model by the handshakes that the coming clock edge will take, then move
    // to the next falling edge.
    task automatic step(input string tag);
        int         s;
        bit         fwd;
        logic [3:0] e_slv_valid;
        logic       e_req_ready;
        logic       e_rsp_valid;
        logic [31:0] e_rdata;
        logic       e_err;
        logic [3:0] e_rsp_ready;
        #1;
        s   = ref_decode(mst_req_addr);
        fwd = (s >= 0) && !err_pend && (q.size() < MAXT) &&
              ((q.size() == 0) || (q[0] == s));
        e_slv_valid = (fwd && mst_req_valid) ? 4'(1 << s) : 4'h0;
        e_req_ready = fwd ? slv_req_ready[s] : ((s < 0) && !err_pend && (q.size() == 0));
        e_rsp_valid = 1'b0;
        e_rdata     = 32'h0;
        e_err       = 1'b0;
        e_rsp_ready = 4'h0;
        if (err_pend) begin
            e_rsp_valid = 1'b1;
            e_err       = 1'b1;
        end else if (q.size() > 0) begin
            e_rsp_valid = slv_rsp_valid[q[0]];
            e_rdata     = slv_rsp_rdata[q[0]];
            e_err       = slv_rsp_err[q[0]];
            e_rsp_ready = 4'(mst_rsp_ready) << q[0];
        end
        chk({tag, ".req_ready"}, 64'(mst_req_ready), 64'(e_req_ready));
        chk({tag, ".slv_req_valid"}, 64'(slv_req_valid), 64'(e_slv_valid));
        chk({tag, ".slv_req_addr"}, 64'(slv_req_addr), 64'(mst_req_addr));
        chk({tag, ".rsp_valid"}, 64'(mst_rsp_valid), 64'(e_rsp_valid));
        chk({tag, ".slv_rsp_ready"}, 64'(slv_rsp_ready), 64'(e_rsp_ready));
        if (e_rsp_valid) begin
            chk({tag, ".rsp_rdata"}, 64'(mst_rsp_rdata), 64'(e_rdata));
            chk({tag, ".rsp_err"}, 64'(mst_rsp_err), 64'(e_err));
        end
        if (err_pend) begin
            if (mst_rsp_ready) err_pend = 0;
        end else if (e_rsp_valid && mst_rsp_ready) begin
            void'(q.pop_front());
        end
        if (mst_req_valid && e_req_ready) begin
            if (s >= 0) q.push_back(s);
            else        err_pend = 1;
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        mst_req_valid = 1'b0;
        slv_rsp_valid = 4'hF;
        mst_rsp_ready = 1'b1;
        for (int i = 0; i < 2 * MAXT + 2; i++) begin
            if (q.size() == 0 && !err_pend) break;
            step(tag);
        end
        slv_rsp_valid = 4'h0;
        mst_rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset: outputs quiet even with slaves presenting responses.
        idle_inputs();
        slv_rsp_valid = 4'hF;
        mst_rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst.rsp_valid", 64'(mst_rsp_valid), 64'd0);
        chk("rst.slv_rsp_ready", 64'(slv_rsp_ready), 64'd0);
        chk("rst.slv_req_valid", 64'(slv_req_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        step("idle");

        // Single read to slave1, answered on the following cycle.
        mst_req_valid = 1'b1;
        mst_req_addr  = 32'h1004;
        slv_req_ready = 4'hF;
        #1;
        chk("t1.slv_req_valid", 64'(slv_req_valid), 64'h2);
        step("t1.req");
        mst_req_valid    = 1'b0;
        slv_rsp_valid    = 4'b0010;
        slv_rsp_rdata[1] = 32'hDEADBEEF;
        mst_rsp_ready    = 1'b1;
        #1;
        chk("t1.rdata", 64'(mst_rsp_rdata), 64'hDEADBEEF);
        chk("t1.err", 64'(mst_rsp_err), 64'd0);
        step("t1.rsp");
        idle_inputs();
        step("t1.idle");

        // Four writes to slave2 with responses held back, then a fifth.
        slv_req_ready = 4'hF;
        mst_req_valid = 1'b1;
        mst_req_we    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mst_req_addr  = 32'h2000 + 32'(4 * i);
            mst_req_wdata = 32'(i);
            mst_req_be    = 4'hF;
            step("t2.wr");
        end
        mst_req_addr = 32'h2010;
        #1;
        chk("t2.full_stall", 64'(mst_req_ready), 64'd0);
        step("t2.full");
        slv_rsp_valid = 4'b0100;
        mst_rsp_ready = 1'b1;
        #1;
        chk("t2.no_lookahead", 64'(mst_req_ready), 64'd0);
        step("t2.rsp");
        slv_rsp_valid = 4'h0;
        #1;
        chk("t2.resume", 64'(mst_req_ready), 64'd1);
        step("t2.resume");
        drain("t2.drain");

        // Target change waits for both slave1 responses.
        mst_req_valid = 1'b1;
        mst_req_we    = 1'b0;
        mst_req_addr  = 32'h1000;
        slv_req_ready = 4'hF;
        step("t3.a");
        step("t3.b");
        mst_req_addr = 32'h0010;
        #1;
        chk("t3.stall_ready", 64'(mst_req_ready), 64'd0);
        chk("t3.stall_valid", 64'(slv_req_valid), 64'd0);
        step("t3.stall");
        mst_rsp_ready = 1'b1;
        slv_rsp_valid = 4'b0011;
        step("t3.rsp1");
        step("t3.rsp2");
        slv_rsp_valid = 4'h0;
        #1;
        chk("t3.forward", 64'(slv_req_valid), 64'h1);
        step("t3.fwd");
        drain("t3.drain");

        // Unmapped request terminates internally with a held error response.
        idle_inputs();
        mst_req_valid = 1'b1;
        mst_req_addr  = 32'h5000;
        slv_req_ready = 4'hF;
        #1;
        chk("t4.accept", 64'(mst_req_ready), 64'd1);
        step("t4.req");
        mst_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4.held", 64'({mst_rsp_valid, mst_rsp_err, mst_rsp_rdata}), {32'd0, 2'b11, 32'd0});
            step("t4.hold");
        end
        mst_rsp_ready = 1'b1;
        step("t4.ack");
        step("t4.idle");

        // Request and response handshake together at two outstanding.
        idle_inputs();
        mst_req_valid = 1'b1;
        mst_req_addr  = 32'h2000;
        slv_req_ready = 4'hF;
        step("t5.a");
        step("t5.b");
        slv_rsp_valid = 4'b0100;
        mst_rsp_ready = 1'b1;
        step("t5.both");
        slv_rsp_valid = 4'h0;
        mst_rsp_ready = 1'b0;
        step("t5.c");
        step("t5.d");
        #1;
        chk("t5.full_after_2", 64'(mst_req_ready), 64'd0);
        step("t5.full");
        drain("t5.drain");

        // Random traffic against the model.
        begin
            int cur = 0;
            for (int c = 0; c < 600; c++) begin
                int pick = $urandom_range(0, 9);
                if (pick >= 6 && pick < 9) cur = $urandom_range(0, 3);
                mst_req_valid = ($urandom_range(0, 3) != 0);
                mst_req_addr  = (pick == 9) ? (32'h5000 | 32'($urandom_range(0, 4095)))
                                            : (slave_base(cur) | 32'($urandom_range(0, 4095)));
                mst_req_we    = 1'($urandom);
                mst_req_wdata = $urandom;
                mst_req_be    = 4'($urandom);
                mst_rsp_ready = ($urandom_range(0, 3) != 0);
                slv_req_ready = 4'($urandom);
                slv_rsp_valid = 4'($urandom);
                slv_rsp_err   = 4'($urandom);
                for (int k = 0; k < 4; k++) slv_rsp_rdata[k] = $urandom;
                step("rnd");
            end
            drain("rnd.drain");
        end

        // Reset with three outstanding clears state asynchronously.
        idle_inputs();
        mst_req_valid = 1'b1;
        mst_req_addr  = 32'h8000;
        slv_req_ready = 4'hF;
        step("t6.a");
        step("t6.b");
        step("t6.c");
        mst_req_valid = 1'b0;
        slv_rsp_valid = 4'b1000;
        #1;
        chk("t6.pre_valid", 64'(mst_rsp_valid), 64'd1);
        step("t6.pre");
        #2;
        rst_n         = 1'b0;
        mst_rsp_ready = 1'b1;
        #1;
        chk("t6.rst_rsp_valid", 64'(mst_rsp_valid), 64'd0);
        chk("t6.rst_rsp_ready", 64'(slv_rsp_ready), 64'd0);
        q.delete();
        err_pend = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step("t6.orphan");
        mst_req_valid = 1'b1;
        mst_req_addr  = 32'h0020;
        #1;
        chk("t6.new_target", 64'(slv_req_valid), 64'h1);
        step("t6.new");
        drain("t6.drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_addr_req_demux
`default_nettype wire
